// File: rtl/proc_control_pkg.sv
// Shared constants for the multi-cycle control unit: datapath widths,
// opcode field values, timestep state encodings and ALU select codes.
package proc_control_pkg;

  localparam int DATA_W = 16;  // DIN width; only the low IR_W bits form an instruction
  localparam int IR_W   = 9;   // III XXX YYY
  localparam int NREG   = 8;   // fixed by the 3-bit X/Y fields

  // Opcode field IR[8:6]; 1xx decodes as a no-op
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Timestep states
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/proc_control_dec3to8.sv
// dec3to8: 3-bit code to one-hot 8 with enable.
// Ports:
//   w   in  3  code
//   en  in  1  enable; y is all zero when low
//   y   out 8  one-hot output, y[w] set when enabled
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_bit
      assign y[i] = en && (w == 3'(i));
    end
  endgenerate

endmodule

// File: rtl/proc_control.sv
// proc_control: multi-cycle control unit for the 8-register ALU datapath.
// Latches an instruction from DIN in T0 and sequences bus/register/ALU
// enables over T1..T3, pulsing Done on the final cycle of each instruction.
// Ports:
//   Clock     in   1       rising-edge clock
//   Resetn    in   1       async reset, active low
//   Run       in   1       start request, sampled only in T0
//   DIN       in   DATA_W  instruction word / immediate
//   IRin      out  1       instruction register load
//   Rin       out  NREG    one-hot register write enables
//   Rout      out  NREG    one-hot register bus drive enables
//   Ain       out  1       load ALU operand A
//   Gin       out  1       load result register G
//   Gout      out  1       G drives bus
//   DINout    out  1       DIN drives bus
//   Operacao  out  2       ALU select (00 add, 01 sub)
//   Done      out  1       last cycle of the instruction
import proc_control_pkg::*;

module proc_control (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              DINout,
  output logic [1:0]        Operacao,
  output logic              Done
);

  logic [1:0]      state, nxt;
  logic [IR_W-1:0] ir;
  logic [2:0]      op;
  logic [NREG-1:0] xoh, yoh;

  // Only the instruction bits of DIN are latched; the rest is the immediate path.
  logic unused_din;
  assign unused_din = ^DIN[DATA_W-1:IR_W];

  assign op = ir[8:6];

  // Decoders idle in T0 where IR may be stale or being reloaded.
  dec3to8 u_decx (.w(ir[5:3]), .en(state != T0), .y(xoh));
  dec3to8 u_decy (.w(ir[2:0]), .en(state != T0), .y(yoh));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (IRin) ir <= DIN[IR_W-1:0];
    end
  end

  always_comb begin
    nxt      = state;
    IRin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    Operacao = ALU_ADD;
    Done     = 1'b0;
    case (state)
      T0: begin
        // Gated by Resetn so no IR load is requested while reset is held.
        IRin = Run & Resetn;
        if (Run) nxt = T1;
      end
      T1: begin
        case (op)
          OP_MV: begin
            Rout = yoh;
            Rin  = xoh;
            Done = 1'b1;
            nxt  = T0;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = xoh;
            Done   = 1'b1;
            nxt    = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout = xoh;
            Ain  = 1'b1;
            nxt  = T2;
          end
          default: begin
            Done = 1'b1;
            nxt  = T0;
          end
        endcase
      end
      T2: begin
        // Only add/sub reach T2.
        Rout     = yoh;
        Gin      = 1'b1;
        Operacao = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
        nxt      = T3;
      end
      default: begin
        Gout = 1'b1;
        Rin  = xoh;
        Done = 1'b1;
        nxt  = T0;
      end
    endcase
  end

endmodule
